mul_seq_unit: RTL and testbench

- Multi-cycle iterative shift-add multiplier with its own sequencing FSM.
- Sits in the EXE stage and replaces the single-cycle EXE_MUL path for instructions the decoder flags Is_Mul.
- Asserts freeze to stall IF/ID/EXE while the product is computed, then presents a truncated WIDTH-bit result to the EXE/MEM register.
- Honours branch/jump flushes so a killed MUL never writes back.

---
 rtl/mul_seq_unit.sv | 127 ++++++++++++
 tb/tb_mul_seq_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: iterative shift-add multiplier for the EXE stage.
// A MUL flagged by the decoder is launched from IDLE. The unit then retires
// UNROLL multiplier bits per BUSY cycle. When it finishes, it spends one DONE
// cycle presenting the low WIDTH bits of the product to the EXE/MEM register.
// freeze stalls IF/ID/EXE and the PC while the product is being built.
module mul_seq_unit #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1,
  parameter int STEPS  = WIDTH / UNROLL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             freeze,
  output logic             busy
);

  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               done_q;

  logic [WIDTH-1:0]   partial_d;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   mcand_d;
  logic [WIDTH-1:0]   mplier_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               lastStep;

  // One BUSY step: add the shifted multiplicand for each retired multiplier bit
  // and decide whether this is the final step. A step is final either when no
  // set multiplier bits remain or when the step budget is used up.
  always_comb begin
    partial_d = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (mplier_q[u]) begin
        partial_d = partial_d + (mcand_q << u);
      end
    end
    acc_d    = acc_q + partial_d;
    mcand_d  = mcand_q << UNROLL;
    mplier_d = mplier_q >> UNROLL;
    cnt_d    = cnt_q + 1'b1;
    lastStep = (mplier_d == '0) || (cnt_q == LAST_CNT);
  end

  // Sequencing FSM with datapath registers.
  // A flush in BUSY abandons the product without touching result.
  // DONE lasts one cycle and never relaunches, because the same MUL still sits in EXE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            if (lastStep) begin
              result_q <= acc_d;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // freeze is combinational so the launching cycle already stalls the front end.
  // It drops in DONE so that EXE/MEM captures the product.
  always_comb begin
    freeze = !rst && (((state_q == IDLE) && start && !flush) ||
                      ((state_q == BUSY) && !flush));
    busy   = !rst && (state_q == BUSY);
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb_mul_seq_unit: directed and randomized checks of mul_seq_unit.
// Two instances are used, one with UNROLL=1 and one with UNROLL=4.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_mul_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        startSig  [2];
  logic        flushSig  [2];
  logic [31:0] opASig    [2];
  logic [31:0] opBSig    [2];
  logic [31:0] resultSig [2];
  logic        doneSig   [2];
  logic        freezeSig [2];
  logic        busySig   [2];

  int checks   = 0;
  int failures = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  mul_seq_unit #(.WIDTH(32), .UNROLL(1)) dutU1 (
    .clk(clk), .rst(rst), .start(startSig[0]), .flush(flushSig[0]),
    .op_a(opASig[0]), .op_b(opBSig[0]), .result(resultSig[0]),
    .done(doneSig[0]), .freeze(freezeSig[0]), .busy(busySig[0])
  );

  mul_seq_unit #(.WIDTH(32), .UNROLL(4)) dutU4 (
    .clk(clk), .rst(rst), .start(startSig[1]), .flush(flushSig[1]),
    .op_a(opASig[1]), .op_b(opBSig[1]), .result(resultSig[1]),
    .done(doneSig[1]), .freeze(freezeSig[1]), .busy(busySig[1])
  );

  function automatic int unrollOf(input int sel);
    return (sel == 0) ? 1 : 4;
  endfunction

  // Busy cycles = ceil(significant bits of multiplier / unroll), minimum 1.
  function automatic int busyCycles(input logic [31:0] b, input int u);
    int len = 0;
    for (int i = 0; i < 32; i++) if (b[i]) len = i + 1;
    return (len == 0) ? 1 : (len + u - 1) / u;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Launch one MUL in the next cycle and follow it through to its DONE cycle.
  // On return, the DONE cycle is current and the inputs have just been sampled.
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                               input bit holdStart);
    int          n;
    int          busyCnt   = 0;
    int          freezeCnt = 0;
    bit          seenDone  = 1'b0;
    logic [31:0] expRes;
    n      = busyCycles(b, unrollOf(sel));
    expRes = a * b;
    nextCycle();
    startSig[sel] = 1'b1;
    flushSig[sel] = 1'b0;
    opASig[sel]   = a;
    opBSig[sel]   = b;
    #1;
    checkBit("launch_freeze", freezeSig[sel], 1'b1);
    checkBit("launch_busy", busySig[sel], 1'b0);
    if (freezeSig[sel]) freezeCnt++;
    for (int c = 0; c < 60 && !seenDone; c++) begin
      nextCycle();
      if (!holdStart) startSig[sel] = 1'b0;
      #1;
      if (doneSig[sel] === 1'b1) seenDone = 1'b1;
      else begin
        if (busySig[sel] === 1'b1) busyCnt++;
        if (freezeSig[sel] === 1'b1) freezeCnt++;
      end
    end
    checkBit("done_seen", seenDone, 1'b1);
    checkOutput("busy_cycles", busyCnt, n);
    checkOutput("freeze_cycles", freezeCnt, n + 1);
    checkOutput("result", resultSig[sel], expRes);
    checkBit("done_freeze", freezeSig[sel], 1'b0);
    checkBit("done_busy", busySig[sel], 1'b0);
  endtask

  // Idle cycle after DONE: no pulse, no activity, and the product is held.
  task automatic idleCheck(input int sel, input logic [31:0] expRes);
    nextCycle();
    startSig[sel] = 1'b0;
    flushSig[sel] = 1'b0;
    #1;
    checkBit("idle_done", doneSig[sel], 1'b0);
    checkBit("idle_busy", busySig[sel], 1'b0);
    checkBit("idle_freeze", freezeSig[sel], 1'b0);
    checkOutput("idle_result", resultSig[sel], expRes);
  endtask

  // Watch for a number of cycles and require that done never pulses and the result holds.
  task automatic quietCheck(input int sel, input int cycles, input logic [31:0] expRes);
    int pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      nextCycle();
      if (doneSig[sel] !== 1'b0) pulses++;
    end
    checkOutput("no_done_pulse", pulses, 0);
    checkOutput("result_kept", resultSig[sel], expRes);
  endtask

  // Directed sequence first, then randomized operands, then reset in mid-BUSY.
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      startSig[s] = 1'b1;
      flushSig[s] = 1'b0;
      opASig[s]   = 32'd3;
      opBSig[s]   = 32'd3;
    end
    #2;
    checkBit("rst_freeze", freezeSig[0], 1'b0);
    checkBit("rst_busy", busySig[0], 1'b0);
    nextCycle();
    nextCycle();
    checkBit("rst_freeze_u4", freezeSig[1], 1'b0);
    checkOutput("rst_result", resultSig[0], 32'd0);
    checkBit("rst_done", doneSig[0], 1'b0);
    checkOutput("rst_result_u4", resultSig[1], 32'd0);
    rst = 1'b0;
    startSig[0] = 1'b0;
    startSig[1] = 1'b0;

    applyStimulus(0, 32'd7, 32'd5, 1'b0);
    idleCheck(0, 32'd35);
    applyStimulus(0, 32'd3, 32'hFFFF_FFFF, 1'b0);
    idleCheck(0, 32'hFFFF_FFFD);
    applyStimulus(0, 32'h1234, 32'd0, 1'b0);
    idleCheck(0, 32'd0);
    applyStimulus(1, 32'd2, 32'h100, 1'b0);
    idleCheck(1, 32'h200);

    // Re-establish 35, then flush the second BUSY cycle of a new launch.
    applyStimulus(0, 32'd7, 32'd5, 1'b0);
    idleCheck(0, 32'd35);
    nextCycle();
    startSig[0] = 1'b1;
    opASig[0]   = 32'd7;
    opBSig[0]   = 32'd5;
    #1;
    checkBit("fl_launch_freeze", freezeSig[0], 1'b1);
    nextCycle();
    startSig[0] = 1'b0;
    #1;
    checkBit("fl_busy1", busySig[0], 1'b1);
    nextCycle();
    flushSig[0] = 1'b1;
    #1;
    checkBit("fl_freeze", freezeSig[0], 1'b0);
    checkBit("fl_busy2", busySig[0], 1'b1);
    nextCycle();
    flushSig[0] = 1'b0;
    #1;
    checkBit("fl_idle_busy", busySig[0], 1'b0);
    checkBit("fl_idle_done", doneSig[0], 1'b0);
    quietCheck(0, 6, 32'd35);

    // A flush together with start in IDLE must not launch.
    nextCycle();
    startSig[0] = 1'b1;
    flushSig[0] = 1'b1;
    opASig[0]   = 32'd9;
    opBSig[0]   = 32'd9;
    #1;
    checkBit("fl_start_freeze", freezeSig[0], 1'b0);
    nextCycle();
    startSig[0] = 1'b0;
    flushSig[0] = 1'b0;
    #1;
    checkBit("fl_start_busy", busySig[0], 1'b0);
    quietCheck(0, 4, 32'd35);

    // Hold start through DONE, then launch back-to-back in the next IDLE cycle.
    applyStimulus(0, 32'd11, 32'd13, 1'b1);
    applyStimulus(0, 32'd6, 32'd6, 1'b0);
    idleCheck(0, 32'd36);

    // Randomized operands; the multiplier is shifted to vary its significant length.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      applyStimulus(i % 2, a, b, 1'b0);
      if (i % 3 == 0) idleCheck(i % 2, a * b);
    end

    // Reset in mid-BUSY: IDLE with a cleared result on the next edge.
    applyStimulus(0, 32'd9, 32'd9, 1'b0);
    nextCycle();
    startSig[0] = 1'b1;
    opASig[0]   = 32'd6;
    opBSig[0]   = 32'hFF;
    #1;
    nextCycle();
    startSig[0] = 1'b0;
    #1;
    checkBit("rb_busy", busySig[0], 1'b1);
    nextCycle();
    rst = 1'b1;
    #1;
    checkBit("rb_rst_freeze", freezeSig[0], 1'b0);
    checkBit("rb_rst_busy", busySig[0], 1'b0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkBit("rb_idle_busy", busySig[0], 1'b0);
    checkBit("rb_idle_done", doneSig[0], 1'b0);
    checkOutput("rb_result", resultSig[0], 32'd0);
    quietCheck(0, 10, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
